// File: rtl/adc_sequencer.sv
// Dual-slope integrator sequencer.
// Drives the DG444 switch controls through the SHORT, RUNUP and RUNDOWN phases. It measures
// the run-down time against the comparator and latches the count behind a valid/ack handshake.
//
// Ports:
//   clk, rst_n    system clock, asynchronous active-low reset
//   start         one-cycle conversion request, sampled only in IDLE
//   t_trigger     comparator output, asynchronous to clk
//   m_reset       0 = integrator cap shorted, 1 = integrating
//   m_in          0 = input selected, 1 = reference selected
//   m_ref         complement of m_in
//   busy          high outside IDLE
//   result        latched run-down count (CW bits)
//   result_valid  result holds an unread conversion
//   result_ack    consumer has taken result
//   overrun       sticky: a valid result was overwritten before being acked
//   timeout       last conversion aborted on the run-down limit
module adc_sequencer #(
    parameter int unsigned RESET_CYCLES   = 1000,
    parameter int unsigned RUNUP_CYCLES   = 1000000,
    parameter int unsigned TIMEOUT_CYCLES = 4000000,
    parameter int unsigned CW             = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          t_trigger,
    output logic          m_reset,
    output logic          m_in,
    output logic          m_ref,
    output logic          busy,
    output logic [CW-1:0] result,
    output logic          result_valid,
    input  logic          result_ack,
    output logic          overrun,
    output logic          timeout
);

    localparam logic [CW-1:0] ResetLast  = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] RunupLast  = CW'(RUNUP_CYCLES - 1);
    localparam logic [CW-1:0] TimeoutVal = CW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {StIdle, StShort, StRunup, StRundown} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [CW-1:0] result_q, result_d;
    logic          valid_q, valid_d;
    logic          overrun_q, overrun_d;
    logic          timeout_q, timeout_d;
    logic          m_reset_q, m_reset_d;
    logic          m_in_q, m_in_d;
    logic          busy_q, busy_d;
    logic          sync1_q, sync2_q, hist_q;
    logic          crossing;
    logic          new_res;

    // Rising edge of the synchronised comparator.
    assign crossing = sync2_q & ~hist_q;

    // In RUNDOWN the counter enters at 0, so cnt_inc equals k in the k-th cycle.
    assign cnt_inc = cnt_q + CW'(1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        timeout_d = timeout_q;
        new_res   = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StShort;
                    cnt_d   = '0;
                end
            end
            StShort: begin
                if (cnt_q == ResetLast) begin
                    state_d = StRunup;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StRunup: begin
                if (cnt_q == RunupLast) begin
                    state_d = StRundown;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StRundown: begin
                cnt_d = cnt_inc;
                if (crossing) begin
                    result_d  = cnt_inc;
                    timeout_d = 1'b0;
                    new_res   = 1'b1;
                    state_d   = StIdle;
                end else if (cnt_inc == TimeoutVal) begin
                    result_d  = TimeoutVal;
                    timeout_d = 1'b1;
                    new_res   = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // A landing result always wins over an ack in the same cycle.
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (new_res) begin
            valid_d = 1'b1;
            if (valid_q && !result_ack) begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && result_ack) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end

        // Switch controls are registered from the next state so they change with the state.
        m_reset_d = (state_d == StRunup) || (state_d == StRundown);
        m_in_d    = (state_d != StRunup);
        busy_d    = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            result_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
            m_reset_q <= 1'b0;
            m_in_q    <= 1'b1;
            busy_q    <= 1'b0;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            hist_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
            m_reset_q <= m_reset_d;
            m_in_q    <= m_in_d;
            busy_q    <= busy_d;
            sync1_q   <= t_trigger;
            sync2_q   <= sync1_q;
            hist_q    <= sync2_q;
        end
    end

    assign m_reset      = m_reset_q;
    assign m_in         = m_in_q;
    assign m_ref        = ~m_in_q;
    assign busy         = busy_q;
    assign result       = result_q;
    assign result_valid = valid_q;
    assign overrun      = overrun_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_adc_sequencer.sv
// Self-checking bench for adc_sequencer with small phase lengths.
// Expected results are queued when a conversion is launched. They are popped and compared
// when busy falls.
module tb_adc_sequencer;

    localparam int R  = 4;
    localparam int U  = 10;
    localparam int T  = 50;
    localparam int CW = 16;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          t_trigger;
    logic          m_reset;
    logic          m_in;
    logic          m_ref;
    logic          busy;
    logic [CW-1:0] result;
    logic          result_valid;
    logic          result_ack;
    logic          overrun;
    logic          timeout;

    typedef struct {
        logic [CW-1:0] res;
        logic          to;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    logic busy_prev = 1'b0;

    adc_sequencer #(
        .RESET_CYCLES  (R),
        .RUNUP_CYCLES  (U),
        .TIMEOUT_CYCLES(T),
        .CW            (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .t_trigger   (t_trigger),
        .m_reset     (m_reset),
        .m_in        (m_in),
        .m_ref       (m_ref),
        .busy        (busy),
        .result      (result),
        .result_valid(result_valid),
        .result_ack  (result_ack),
        .overrun     (overrun),
        .timeout     (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch a conversion. k = 0 means the comparator never rises (timeout).
    // noise: extra start pulses in every phase plus a comparator glitch during RUNUP.
    // ack_on_exit: result_ack is high in the cycle the new result lands.
    task automatic convert(input int k, input bit noise, input bit ack_on_exit);
        int ex;
        ex = (k == 0) ? T : k;
        sb.push_back('{res: CW'(ex), to: (k == 0)});
        start = 1'b1;
        step();
        for (int c = 1; c <= R + U + T + 4; c++) begin
            if (c == 1) begin
                check_eq("short_busy", 32'(busy), 1);
                check_eq("short_m_reset", 32'(m_reset), 0);
                check_eq("short_m_in", 32'(m_in), 1);
            end
            if (c == R) check_eq("short_end_m_reset", 32'(m_reset), 0);
            if (c == R + 1) begin
                check_eq("runup_m_reset", 32'(m_reset), 1);
                check_eq("runup_m_in", 32'(m_in), 0);
                check_eq("runup_m_ref", 32'(m_ref), 1);
            end
            if (c == R + U) check_eq("runup_end_m_in", 32'(m_in), 0);
            if (c == R + U + 1) begin
                check_eq("rundown_m_in", 32'(m_in), 1);
                check_eq("rundown_m_reset", 32'(m_reset), 1);
            end
            if (c == R + U + ex) check_eq("last_rundown_busy", 32'(busy), 1);
            if (c == R + U + ex + 1) begin
                check_eq("exit_busy", 32'(busy), 0);
                check_eq("exit_m_reset", 32'(m_reset), 0);
                check_eq("exit_m_in", 32'(m_in), 1);
                check_eq("exit_m_ref", 32'(m_ref), 0);
                break;
            end
            start = noise && (c == 2 || c == R + 3 || c == R + U + 2 || c == R + U + ex);
            if (noise && c == R + 2) t_trigger = 1'b1;
            if (noise && c == R + 4) t_trigger = 1'b0;
            // Two synchroniser stages put the crossing two cycles after the pin rises.
            if (k != 0 && c == R + U + k - 2) t_trigger = 1'b1;
            result_ack = ack_on_exit && (c == R + U + ex);
            step();
        end
        start      = 1'b0;
        result_ack = 1'b0;
        t_trigger  = 1'b0;
        if (noise) begin
            step();
            check_eq("start_at_exit_ignored", 32'(busy), 0);
        end
    endtask

    task automatic ack_pulse();
        result_ack = 1'b1;
        step();
        result_ack = 1'b0;
    endtask

    // Scoreboard: each completed conversion shows up as busy falling outside reset.
    always @(negedge clk) begin
        if (!rst_n) begin
            busy_prev = 1'b0;
        end else begin
            if (busy_prev && !busy) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_result", 32'(sb.size()), 1);
                end else begin
                    mon_e = sb.pop_front();
                    check_eq("result", 32'(result), 32'(mon_e.res));
                    check_eq("timeout", 32'(timeout), 32'(mon_e.to));
                    check_eq("result_valid", 32'(result_valid), 1);
                end
            end
            busy_prev = busy;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b1;
        start      = 1'b0;
        t_trigger  = 1'b0;
        result_ack = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_m_reset", 32'(m_reset), 0);
        check_eq("rst_m_in", 32'(m_in), 1);
        check_eq("rst_m_ref", 32'(m_ref), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_result", 32'(result), 0);
        check_eq("rst_valid", 32'(result_valid), 0);
        check_eq("rst_overrun", 32'(overrun), 0);
        check_eq("rst_timeout", 32'(timeout), 0);
        rst_n = 1'b1;
        step();

        // 1: crossing at k=7, then ack clears valid.
        convert(7, 1'b0, 1'b0);
        check_eq("s1_overrun", 32'(overrun), 0);
        ack_pulse();
        check_eq("s1_ack_valid", 32'(result_valid), 0);

        // 2: no crossing, run-down times out.
        convert(0, 1'b0, 1'b0);
        check_eq("s2_valid", 32'(result_valid), 1);
        check_eq("s2_overrun", 32'(overrun), 0);
        ack_pulse();

        // 3: two results without an ack in between.
        convert(7, 1'b0, 1'b0);
        convert(12, 1'b0, 1'b0);
        check_eq("s3_overrun", 32'(overrun), 1);
        check_eq("s3_valid", 32'(result_valid), 1);
        ack_pulse();
        check_eq("s3_ack_valid", 32'(result_valid), 0);
        check_eq("s3_ack_overrun", 32'(overrun), 0);
        ack_pulse();
        check_eq("s3_idle_ack_valid", 32'(result_valid), 0);

        // 4: stray starts and a comparator glitch in RUNUP change nothing.
        convert(7, 1'b1, 1'b0);
        check_eq("s4_overrun", 32'(overrun), 0);
        check_eq("s4_valid", 32'(result_valid), 1);

        // 5: overwrite sets overrun; an ack coinciding with a new result leaves it set.
        convert(5, 1'b0, 1'b0);
        check_eq("s5_overrun_set", 32'(overrun), 1);
        convert(9, 1'b0, 1'b1);
        check_eq("s5_valid", 32'(result_valid), 1);
        check_eq("s5_overrun_kept", 32'(overrun), 1);
        ack_pulse();
        check_eq("s5_ack_valid", 32'(result_valid), 0);
        check_eq("s5_ack_overrun", 32'(overrun), 0);

        // 6: asynchronous reset in mid-RUNUP, with a result pending.
        convert(6, 1'b0, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (R + 2) step();
        check_eq("s6_pre_m_reset", 32'(m_reset), 1);
        rst_n = 1'b0;
        #1;
        check_eq("s6_m_reset", 32'(m_reset), 0);
        check_eq("s6_m_in", 32'(m_in), 1);
        check_eq("s6_busy", 32'(busy), 0);
        check_eq("s6_valid", 32'(result_valid), 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        convert(10, 1'b0, 1'b0);
        check_eq("s6_after_valid", 32'(result_valid), 1);
        check_eq("s6_after_overrun", 32'(overrun), 0);

        repeat (3) step();
        check_eq("sb_drained", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
